// File: rtl/blink_arb_pkg.sv
// blink_arb_pkg: shared types and defaults for the LED blink arbiter.
package blink_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int CBITS_DEF = 24;
  localparam int PBITS_DEF = 8;

  // Width of the round-robin pointer; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/blink_arbiter_if.sv
// blink_arbiter_if: requester-side bundle (requests, patterns, bit period)
// and the LED/status outputs of the arbiter.
interface blink_arbiter_if
  import blink_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CBITS = CBITS_DEF,
  parameter int PBITS = PBITS_DEF
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*PBITS-1:0] pattern;
  logic [CBITS-1:0]      div;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  busy;
  logic                  led;
  logic                  tick;

  modport master (output req, pattern, div, input gnt, done, busy, led, tick);
  modport slave  (input req, pattern, div, output gnt, done, busy, led, tick);

endinterface

// File: rtl/blink_tick.sv
// blink_tick: bit-period prescaler. Down-counter reloaded from period; tick
// is registered and high during the last cycle of every period. tick_nxt is
// the value tick takes after the next edge, so the caller can register
// outputs that must line up with tick.
module blink_tick #(
  parameter int CBITS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [CBITS-1:0] period,
  output logic             tick,
  output logic             tick_nxt
);

  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_nxt;

  // Next count: restart on clear or terminal count, otherwise count down.
  always_comb begin
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
    if (clr) begin
      cnt_nxt  = period;
      tick_nxt = (period == '0);
    end else if (run) begin
      if (tick) begin
        cnt_nxt  = period;
        tick_nxt = (period == '0);
      end else begin
        cnt_nxt  = cnt - CBITS'(1);
        tick_nxt = (cnt == CBITS'(1));
      end
    end
  end

  // Counter and registered tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= tick_nxt;
    end
  end

endmodule

// File: rtl/blink_arbiter.sv
// blink_arbiter: round-robin sharing of one LED among NREQ blink patterns.
// Define BLINK_ARB_GAP_EN to append one dark bit period after each pattern.
//
// state | meaning
// IDLE  | no grant; picks the next requester round-robin
// PLAY  | shifting the granted pattern out MSB-first
// GAP   | one dark bit period before releasing the grant
module blink_arbiter
  import blink_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CBITS = CBITS_DEF,
  parameter int PBITS = PBITS_DEF
) (
  input  logic           clk,
  input  logic           rst,
  blink_arbiter_if.slave bus
);

  localparam int PW = clog2(NREQ);
  localparam int BW = $clog2(PBITS + 1);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic             any_req;
  logic [PBITS-1:0] win_pat;
  logic [PBITS-1:0] shreg;
  logic [CBITS-1:0] div_q;
  logic [CBITS-1:0] period;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bit_nxt;
  logic [NREQ-1:0]  gnt_q;
  logic             led_q;
  logic             done_q;
  logic             busy_q;
  logic             tick;
  logic             tick_nxt;
  logic             grant;
  logic             abort;
  logic             fin;
  logic             run;
  logic             last_nxt;

  // Round-robin pick: first set request at or above the pointer, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && bus.req[(int'(ptr) + i) % NREQ]) begin
        any_req = 1'b1;
        win     = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign win_pat = bus.pattern[int'(win)*PBITS +: PBITS];

  // Playback control: abort, finish, and whether the next cycle is the last
  // tick of the playback (done is registered to coincide with that tick).
  always_comb begin
    grant   = (state == IDLE) && any_req;
    abort   = (state != IDLE) && ((gnt_q & bus.req) == '0);
    bit_nxt = tick ? bitcnt + BW'(1) : bitcnt;
`ifdef BLINK_ARB_GAP_EN
    fin      = tick && (state == GAP);
    last_nxt = ((state == PLAY) && (bit_nxt == BW'(PBITS))) || (state == GAP);
`else
    fin      = tick && (state == PLAY) && (bit_nxt == BW'(PBITS));
    last_nxt = (state == PLAY) && (bit_nxt == BW'(PBITS - 1));
`endif
    run    = (state != IDLE) && !abort && !fin;
    period = (state == IDLE) ? bus.div : div_q;
  end

  blink_tick #(.CBITS(CBITS)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (grant),
    .run      (run),
    .period   (period),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  // Arbitration and playback FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      shreg  <= '0;
      div_q  <= '0;
      bitcnt <= '0;
    end else begin
      done_q <= tick_nxt && last_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q  <= NREQ'(1) << win;
            shreg  <= win_pat;
            led_q  <= win_pat[PBITS-1];
            div_q  <= bus.div;
            bitcnt <= '0;
            ptr    <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
            busy_q <= 1'b1;
            state  <= PLAY;
          end
        end
        PLAY: begin
          if (abort) begin
            state  <= IDLE;
            gnt_q  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end else if (tick) begin
            shreg  <= {shreg[PBITS-2:0], 1'b0};
            bitcnt <= bit_nxt;
            if (bit_nxt == BW'(PBITS)) begin
`ifdef BLINK_ARB_GAP_EN
              state <= GAP;
              led_q <= 1'b0;
`else
              state  <= IDLE;
              gnt_q  <= '0;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
`endif
            end else begin
              led_q <= shreg[PBITS-2];
            end
          end
        end
`ifdef BLINK_ARB_GAP_EN
        GAP: begin
          if (abort || tick) begin
            state  <= IDLE;
            gnt_q  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          gnt_q  <= '0;
          led_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.led  = led_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_blink_arbiter.sv
// tb_blink_arbiter: self-checking bench for blink_arbiter (NREQ=4, PBITS=8).
// Expected LED waveforms come from pattern bits indexed by elapsed time.
module tb_blink_arbiter;

`ifdef BLINK_ARB_GAP_EN
  localparam int PER = 9;
`else
  localparam int PER = 8;
`endif

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   cyc;

  blink_arbiter_if #(.NREQ(4), .CBITS(24), .PBITS(8)) bus ();

  blink_arbiter #(.NREQ(4), .CBITS(24), .PBITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LED level k cycles after the grant edge (k = 1 is the first granted cycle).
  function automatic logic model_led(input logic [7:0] pat, input int d, input int k);
    int b;
    b = (k - 1) / (d + 1);
    if (b < 8) return pat[7 - b];
    return 1'b0;
  endfunction

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    step();
    step();
    got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected %b", got, 8'h00);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int d, L, done_k;
    logic [7:0] pat, exp, got;
    do_reset();
    d = 2; pat = 8'hA5; L = PER * (d + 1); done_k = -1;
    bus.div = 24'(d);
    bus.pattern = {24'h0, pat};
    bus.req = 4'b0001;
    step();
    for (int k = 1; k <= L; k++) begin
      exp = {4'b0001, model_led(pat, d, k), 1'(k == L), 1'(k % (d + 1) == 0), 1'b1};
      got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL single_k%0d: got %b expected %b", k, got, exp);
      end
      if (bus.done === 1'b1 && done_k < 0) done_k = k;
      step();
    end
    tests_run++;
    if (done_k != L) begin
      tests_failed++;
      $display("FAIL single_done_cycle: got %0d expected %0d", done_k, L);
    end
    got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_release: got %b expected %b", got, 8'h00);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_round_robin();
    int c, prev;
    do_reset();
    bus.div = 24'd0;
    bus.pattern = 32'h5A5A_5A5A;
    bus.req = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      c = 0;
      while (bus.gnt == 4'b0000 && c < 100) begin step(); c++; end
      tests_run++;
      if (bus.gnt !== 4'(1 << (g % 4))) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got %b expected %b", g, bus.gnt, 4'(1 << (g % 4)));
      end
      if (g > 0) begin
        tests_run++;
        if (cyc - prev != PER + 1) begin
          tests_failed++;
          $display("FAIL rr_spacing%0d: got %0d expected %0d", g, cyc - prev, PER + 1);
        end
      end
      prev = cyc;
      c = 0;
      while (bus.gnt != 4'b0000 && c < 100) begin step(); c++; end
      tests_run++;
      if (c >= 100) begin
        tests_failed++;
        $display("FAIL rr_release%0d: got timeout expected release", g);
      end
    end
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0100;
    step();
    tests_run++;
    if (bus.gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rr_grant2: got %b expected %b", bus.gnt, 4'b0100);
    end
    c = 0;
    while (bus.gnt != 4'b0000 && c < 100) begin step(); c++; end
    bus.req = 4'b1001;
    step();
    tests_run++;
    if (bus.gnt !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rr_after2: got %b expected %b", bus.gnt, 4'b1000);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_abort();
    logic [7:0] got;
    int c;
    do_reset();
    bus.div = 24'd0;
    bus.pattern = 32'hFFFF_FFFF;
    bus.req = 4'b0011;
    step();
    step(); step(); step();
    got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
    tests_run++;
    if (got !== 8'b0001_1011) begin
      tests_failed++;
      $display("FAIL abort_pre: got %b expected %b", got, 8'b0001_1011);
    end
    bus.req = 4'b0010;
    step();
    got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_drop: got %b expected %b", got, 8'h00);
    end
    step();
    tests_run++;
    if (bus.gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL abort_next: got %b expected %b", bus.gnt, 4'b0010);
    end
    c = 0;
    while (bus.gnt != 4'b0000 && c < 100) begin step(); c++; end
    bus.req = 4'b0000;
  endtask

  task automatic test_sampled();
    int L, done_k;
    logic [7:0] exp, got;
    do_reset();
    L = PER * 2; done_k = -1;
    bus.div = 24'd1;
    bus.pattern = 32'h0000_003C;
    bus.req = 4'b0001;
    step();
    for (int k = 1; k <= L; k++) begin
      exp = {4'b0001, model_led(8'h3C, 1, k), 1'(k == L), 1'(k % 2 == 0), 1'b1};
      got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL sampled_k%0d: got %b expected %b", k, got, exp);
      end
      if (bus.done === 1'b1 && done_k < 0) done_k = k;
      if (k == 3) begin
        bus.div = 24'd7;
        bus.pattern = 32'hFFFF_FFFF;
      end
      step();
    end
    tests_run++;
    if (done_k != L) begin
      tests_failed++;
      $display("FAIL sampled_done_cycle: got %0d expected %0d", done_k, L);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_random();
    int ptr, w, d, L;
    logic [3:0] r, oh;
    logic [31:0] pats;
    logic [7:0] pat, exp, got;
    do_reset();
    ptr = 0;
    for (int it = 0; it < 16; it++) begin
      r = 4'($urandom_range(1, 15));
      d = $urandom_range(0, 3);
      pats = $urandom;
      bus.req = r;
      bus.div = 24'(d);
      bus.pattern = pats;
      step();
      w = model_pick(r, ptr);
      ptr = (w + 1) % 4;
      oh = 4'(1 << w);
      pat = pats[w*8 +: 8];
      L = PER * (d + 1);
      for (int k = 1; k <= L; k++) begin
        exp = {oh, model_led(pat, d, k), 1'(k == L), 1'(k % (d + 1) == 0), 1'b1};
        got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL random_it%0d_k%0d: got %b expected %b", it, k, got, exp);
        end
        bus.div = 24'($urandom_range(0, 15));
        bus.pattern = $urandom;
        bus.req = 4'($urandom) | oh;
        step();
      end
      got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
      tests_run++;
      if (got !== 8'h00) begin
        tests_failed++;
        $display("FAIL random_release%0d: got %b expected %b", it, got, 8'h00);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    do_reset();
    bus.div = 24'd0;
    bus.pattern = 32'hFFFF_FFFF;
    bus.req = 4'b0100;
    step();
    step(); step();
    got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
    tests_run++;
    if (got !== 8'b0100_1011) begin
      tests_failed++;
      $display("FAIL midreset_pre: got %b expected %b", got, 8'b0100_1011);
    end
    rst = 1'b1;
    #1;
    got = {bus.gnt, bus.led, bus.done, bus.tick, bus.busy};
    tests_run++;
    if (got !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_drop: got %b expected %b", got, 8'h00);
    end
    step();
    rst = 1'b0;
    bus.req = 4'b1100;
    step();
    tests_run++;
    if (bus.gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL midreset_ptr: got %b expected %b", bus.gnt, 4'b0100);
    end
    bus.req = 4'b0000;
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.pattern = 32'h0;
    bus.div = 24'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_sampled();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/blink_arbiter.md
# blink_arbiter

Shares the single board LED between NREQ requesters, each presenting an 8-bit blink pattern. A round-robin arbiter grants one requester at a time. A prescaled tick shifts the granted pattern out MSB-first on `led`, followed by an optional dark gap. The block sits between status sources (error, heartbeat, link-up logic) and the LED pin, and replaces free-running blinkers on that pin.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- CBITS, 24, prescaler counter width
- PBITS, 8, pattern length in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level
- pattern  in  NREQ*PBITS  requester i pattern at bits [i*PBITS +: PBITS]
- div  in  CBITS  bit period minus one, in clk cycles
- gnt  out  NREQ  one-hot grant, registered
- done  out  1  one-cycle pulse at the end of a completed playback
- busy  out  1  high while not IDLE
- led  out  1  LED drive, registered
- tick  out  1  one-cycle pulse at each bit-period boundary

## Operation
- States: IDLE, PLAY, GAP.
- IDLE:
  - If any `req` bit is set, pick the first set bit at or after the RR pointer, searching upward with wrap.
  - On that edge:
    - set `gnt`
    - latch `pattern` of the winner into `shreg` and `div` into `div_q`
    - clear the prescaler and bit counter
    - move the pointer to winner+1 mod NREQ
    - go to PLAY
- PLAY:
  - `led` = `shreg` MSB.
  - The prescaler counts 0..`div_q`. At `div_q` it asserts `tick`, wraps to 0, shifts `shreg` left (zero fill) and increments the bit counter.
  - On the PBITS-th tick, go to GAP with `led` = 0.
- GAP:
  - `led` = 0 for one bit period (`div_q`+1 cycles).
  - `done` pulses on the cycle that period's tick fires. On that edge, clear `gnt` and go to IDLE.
- Abort: if the granted `req` bit is low in PLAY or GAP, go to IDLE on the next edge. `gnt` and `led` go to 0 and `done` does not pulse. The pointer keeps its post-grant value.
- `div` and `pattern` changes after grant have no effect until the next grant.
- `div` = 0 gives one clk cycle per bit.
- Pattern 0x00 still plays its full duration, dark.
- Reset values: `led`=0, `gnt`=0, `done`=0, `busy`=0, `tick`=0, pointer=0, state IDLE. Reset mid-playback drops everything immediately (asynchronous).

## Timing
- `req` high at edge t while in IDLE → at t+1: `gnt` and `busy` high, `led` = pattern MSB.
- Each bit lasts exactly `div_q`+1 cycles.
- Playback length (grant to `done`): with the gap, PBITS+1 bit periods; without it, PBITS periods.
- `done` coincides with the last `tick` and `gnt` is still high in that cycle. `gnt` is low the cycle after.
- The minimum IDLE dwell between grants is one cycle. Back-to-back grants are spaced (periods × (`div_q`+1)) + 1 cycles.
- Simultaneous requests resolve only in IDLE. Requests arriving during PLAY wait and are not queued beyond their level.

## Configuration
- `BLINK_ARB_GAP_EN` defined: GAP state present, as described above.
- Not defined:
  - GAP is removed.
  - `done` pulses on the PBITS-th tick.
  - `led` returns to 0 only in IDLE.
  - Playback is PBITS bit periods.

## Structure
- `blink_arb_pkg` holds:
  - state enum (IDLE, PLAY, GAP)
  - default NREQ/CBITS/PBITS localparams
  - the pointer-width function clog2(NREQ)
- Sub-module `blink_tick`: CBITS prescaler with clear, period input and tick output, reset to 0. It has the same asynchronous reset.
- The round-robin pick is combinational in the top module. All outputs are registered.

## Test plan
- Single request: NREQ=4, `div`=2, `req`=0001, pattern0=0xA5 → `gnt`=0001 one cycle later. `led` sequence is 1,0,1,0,0,1,0,1, each held 3 cycles, then 3 cycles at 0. `done` pulses at cycle 27 after grant.
- Round-robin, pointer starting at 0:
  - All `req` held at 1111 → grants 0001, 0010, 0100, 1000, 0001.
  - After the grant to 2, requests {0,3} → grant to 3.
- Abort: `div`=0, drop `req`0 at the 4th bit → next edge `gnt`=0, `led`=0, `done` stays low. A pending `req`1 is granted one cycle later.
- Sampled inputs: change `div` from 1 to 7 and `pattern` to 0xFF mid-play → bit periods stay 2 cycles and the original pattern completes.
- Reset mid-play: assert `rst` during PLAY → `led`, `gnt`, `busy`, `tick` are 0 immediately. After release, `req`=0100 is granted to requester 2 (pointer back at 0).
- With the macro undefined, repeat scenario 1 → `done` at cycle 24, no dark gap.
